// File: rtl/agac_fark_hesaplayici.sv
// Heap-numbered binary tree: applies one move to each of two nodes, then reports the
// level difference, which target is deeper, and their lowest common ancestor.
module agac_fark_hesaplayici #(
  parameter  int DUGUM_W = 4,
  localparam int SEV_W   = (DUGUM_W <= 2) ? 1 : $clog2(DUGUM_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               giris_gecerli,
  output logic               giris_hazir,
  input  logic [DUGUM_W-1:0] dugum_1,
  input  logic [DUGUM_W-1:0] dugum_2,
  input  logic [1:0]         yon_1,
  input  logic [1:0]         yon_2,
  output logic               cikis_gecerli,
  input  logic               cikis_hazir,
  output logic [SEV_W-1:0]   seviye_farki,
  output logic               derin_dugum,
  output logic [DUGUM_W-1:0] ortak_ata,
  output logic               hata
);

  localparam logic [2:0] BOS    = 3'd0;
  localparam logic [2:0] HEDEF  = 3'd1;
  localparam logic [2:0] SEVIYE = 3'd2;
  localparam logic [2:0] ESITLE = 3'd3;
  localparam logic [2:0] ATA    = 3'd4;
  localparam logic [2:0] SONUC  = 3'd5;

  localparam logic [DUGUM_W-1:0] KOK     = DUGUM_W'(1);
  localparam logic [DUGUM_W-1:0] SIFIR_D = DUGUM_W'(0);
  localparam logic [SEV_W-1:0]   BIR_S   = SEV_W'(1);
  localparam logic [SEV_W-1:0]   SIFIR_S = SEV_W'(0);

  // One extra bit so a child move past the top of the number range is visible.
  function automatic logic [DUGUM_W:0] hareket(input logic [DUGUM_W-1:0] n,
                                               input logic [1:0]         y);
    logic [DUGUM_W:0] r;
    case (y)
      2'b00:   r = {1'b0, n >> 1};
      2'b01:   r = {n, 1'b0};
      2'b10:   r = {n, 1'b1};
      default: r = {1'b0, n};
    endcase
    return r;
  endfunction

  function automatic logic hedef_hatali(input logic [DUGUM_W-1:0] n,
                                        input logic [DUGUM_W:0]   r);
    return (n == SIFIR_D) || (r[DUGUM_W-1:0] == SIFIR_D) || r[DUGUM_W];
  endfunction

  logic [2:0]         state_q, state_d;
  logic [DUGUM_W-1:0] n1_q, n1_d, n2_q, n2_d;
  logic [DUGUM_W-1:0] c1_q, c1_d, c2_q, c2_d;
  logic [1:0]         y1_q, y1_d, y2_q, y2_d;
  logic [SEV_W-1:0]   l1_q, l1_d, l2_q, l2_d;
  logic [SEV_W-1:0]   fark_q, fark_d;
  logic               derin_q, derin_d;
  logic               err_q, err_d;
  logic               giris_hazir_q, giris_hazir_d;
  logic               cikis_gecerli_q, cikis_gecerli_d;
  logic [SEV_W-1:0]   seviye_farki_q, seviye_farki_d;
  logic               derin_dugum_q, derin_dugum_d;
  logic [DUGUM_W-1:0] ortak_ata_q, ortak_ata_d;
  logic               hata_q, hata_d;
  logic [DUGUM_W:0]   hd1_s, hd2_s;

  // Next-state and datapath for the whole sequence.
  always_comb begin
    state_d        = state_q;
    n1_d           = n1_q;
    n2_d           = n2_q;
    c1_d           = c1_q;
    c2_d           = c2_q;
    y1_d           = y1_q;
    y2_d           = y2_q;
    l1_d           = l1_q;
    l2_d           = l2_q;
    fark_d         = fark_q;
    derin_d        = derin_q;
    err_d          = err_q;
    seviye_farki_d = seviye_farki_q;
    derin_dugum_d  = derin_dugum_q;
    ortak_ata_d    = ortak_ata_q;
    hata_d         = hata_q;
    hd1_s          = hareket(n1_q, y1_q);
    hd2_s          = hareket(n2_q, y2_q);

    case (state_q)
      BOS: begin
        if (giris_gecerli) begin
          n1_d    = dugum_1;
          n2_d    = dugum_2;
          y1_d    = yon_1;
          y2_d    = yon_2;
          err_d   = 1'b0;
          state_d = HEDEF;
        end else begin
          state_d = BOS;
        end
      end
      HEDEF: begin
        n1_d    = hd1_s[DUGUM_W-1:0];
        n2_d    = hd2_s[DUGUM_W-1:0];
        c1_d    = hd1_s[DUGUM_W-1:0];
        c2_d    = hd2_s[DUGUM_W-1:0];
        l1_d    = SIFIR_S;
        l2_d    = SIFIR_S;
        err_d   = hedef_hatali(n1_q, hd1_s) || hedef_hatali(n2_q, hd2_s);
        state_d = SEVIYE;
      end
      SEVIYE: begin
        // The registered error flag is forwarded here, so a bad request exits one cycle later.
        if (err_q) begin
          hata_d         = 1'b1;
          seviye_farki_d = SIFIR_S;
          derin_dugum_d  = 1'b0;
          ortak_ata_d    = SIFIR_D;
          state_d        = SONUC;
        end else if ((c1_q == KOK) && (c2_q == KOK)) begin
          fark_d  = (l1_q > l2_q) ? (l1_q - l2_q) : (l2_q - l1_q);
          derin_d = (l2_q > l1_q);
          state_d = ESITLE;
        end else begin
          if (c1_q > KOK) begin
            c1_d = c1_q >> 1;
            l1_d = l1_q + BIR_S;
          end else begin
            c1_d = c1_q;
          end
          if (c2_q > KOK) begin
            c2_d = c2_q >> 1;
            l2_d = l2_q + BIR_S;
          end else begin
            c2_d = c2_q;
          end
        end
      end
      ESITLE: begin
        if (l1_q == l2_q) begin
          state_d = ATA;
        end else if (l1_q > l2_q) begin
          n1_d = n1_q >> 1;
          l1_d = l1_q - BIR_S;
        end else begin
          n2_d = n2_q >> 1;
          l2_d = l2_q - BIR_S;
        end
      end
      ATA: begin
        if (n1_q == n2_q) begin
          hata_d         = 1'b0;
          seviye_farki_d = fark_q;
          derin_dugum_d  = derin_q;
          ortak_ata_d    = n1_q;
          state_d        = SONUC;
        end else begin
          n1_d = n1_q >> 1;
          n2_d = n2_q >> 1;
        end
      end
      SONUC: begin
        if (cikis_hazir) begin
          hata_d         = 1'b0;
          seviye_farki_d = SIFIR_S;
          derin_dugum_d  = 1'b0;
          ortak_ata_d    = SIFIR_D;
          state_d        = BOS;
        end else begin
          state_d = SONUC;
        end
      end
      default: begin
        state_d = BOS;
      end
    endcase

    giris_hazir_d   = (state_d == BOS);
    cikis_gecerli_d = (state_d == SONUC);
  end

  // State, working and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= BOS;
      n1_q            <= SIFIR_D;
      n2_q            <= SIFIR_D;
      c1_q            <= SIFIR_D;
      c2_q            <= SIFIR_D;
      y1_q            <= 2'b00;
      y2_q            <= 2'b00;
      l1_q            <= SIFIR_S;
      l2_q            <= SIFIR_S;
      fark_q          <= SIFIR_S;
      derin_q         <= 1'b0;
      err_q           <= 1'b0;
      giris_hazir_q   <= 1'b1;
      cikis_gecerli_q <= 1'b0;
      seviye_farki_q  <= SIFIR_S;
      derin_dugum_q   <= 1'b0;
      ortak_ata_q     <= SIFIR_D;
      hata_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      n1_q            <= n1_d;
      n2_q            <= n2_d;
      c1_q            <= c1_d;
      c2_q            <= c2_d;
      y1_q            <= y1_d;
      y2_q            <= y2_d;
      l1_q            <= l1_d;
      l2_q            <= l2_d;
      fark_q          <= fark_d;
      derin_q         <= derin_d;
      err_q           <= err_d;
      giris_hazir_q   <= giris_hazir_d;
      cikis_gecerli_q <= cikis_gecerli_d;
      seviye_farki_q  <= seviye_farki_d;
      derin_dugum_q   <= derin_dugum_d;
      ortak_ata_q     <= ortak_ata_d;
      hata_q          <= hata_d;
    end
  end

  assign giris_hazir   = giris_hazir_q;
  assign cikis_gecerli = cikis_gecerli_q;
  assign seviye_farki  = seviye_farki_q;
  assign derin_dugum   = derin_dugum_q;
  assign ortak_ata     = ortak_ata_q;
  assign hata          = hata_q;

endmodule

// File: tb/tb_agac_fark_hesaplayici.sv
// Scoreboard bench for agac_fark_hesaplayici (DUGUM_W=4): a tree-level reference model
// predicts each result and its latency; a monitor checks what the DUT presents.
module tb_agac_fark_hesaplayici;
  localparam int DW   = 4;
  localparam int MAXN = (1 << DW) - 1;

  typedef struct {
    int fark;
    int derin;
    int ata;
    int hata;
    int lat;
    int acc;
  } bek_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          giris_gecerli;
  logic          giris_hazir;
  logic [DW-1:0] dugum_1, dugum_2;
  logic [1:0]    yon_1, yon_2;
  logic          cikis_gecerli;
  logic          cikis_hazir = 1'b0;
  logic [1:0]    seviye_farki;
  logic          derin_dugum;
  logic [DW-1:0] ortak_ata;
  logic          hata;

  bek_t sb[$];
  bek_t anlik;
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;
  int   ncmp = 0;
  int   kip = 1;
  int   vcnt = 0;
  int   son_hs = -1;
  bit   b2b = 1'b0;
  bit   gorundu = 1'b0;

  agac_fark_hesaplayici #(.DUGUM_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .giris_gecerli(giris_gecerli), .giris_hazir(giris_hazir),
    .dugum_1(dugum_1), .dugum_2(dugum_2), .yon_1(yon_1), .yon_2(yon_2),
    .cikis_gecerli(cikis_gecerli), .cikis_hazir(cikis_hazir),
    .seviye_farki(seviye_farki), .derin_dugum(derin_dugum),
    .ortak_ata(ortak_ata), .hata(hata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic kontrol(input string ad, input int got, input int exp);
    ncmp++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", ad, got, exp, cyc);
    end
  endtask

  function automatic int git(input int d, input int y);
    case (y)
      0:       return d / 2;
      1:       return 2 * d;
      2:       return 2 * d + 1;
      default: return d;
    endcase
  endfunction

  function automatic int seviye(input int x);
    int l = 0;
    for (int i = 0; i < 31; i++) if ((x >> i) != 0) l = i;
    return l;
  endfunction

  function automatic bek_t model(input int d1, input int y1, input int d2, input int y2);
    bek_t e;
    int t1, t2, a, b, l1, l2, mx, mn, k;
    t1 = git(d1, y1);
    t2 = git(d2, y2);
    e.acc = 0;
    if (d1 == 0 || d2 == 0 || t1 == 0 || t2 == 0 || t1 > MAXN || t2 > MAXN) begin
      e.fark = 0; e.derin = 0; e.ata = 0; e.hata = 1; e.lat = 2;
    end else begin
      l1 = seviye(t1);
      l2 = seviye(t2);
      a = t1;
      b = t2;
      while (a != b) begin
        if (a > b) a = a / 2;
        else b = b / 2;
      end
      mx = (l1 > l2) ? l1 : l2;
      mn = (l1 > l2) ? l2 : l1;
      k  = mn - seviye(a);
      e.fark = mx - mn; e.derin = (l2 > l1) ? 1 : 0; e.ata = a; e.hata = 0;
      e.lat = 4 + mx + (mx - mn) + k;
    end
    return e;
  endfunction

  // Consumer handshake: random, always ready, or held off for three result cycles.
  always @(posedge clk) begin
    #1;
    if (cikis_gecerli) vcnt++;
    else vcnt = 0;
    case (kip)
      1:       cikis_hazir = 1'b1;
      2:       cikis_hazir = (vcnt >= 4);
      default: cikis_hazir = ($urandom_range(0, 2) != 0);
    endcase
  end

  // Monitor: compares the first cycle of each result, then checks it stays stable.
  always @(negedge clk) begin
    if (rst_n && cikis_gecerli) begin
      kontrol("giris_hazir_in_sonuc", giris_hazir, 0);
      if (!gorundu) begin
        if (sb.size() == 0) begin
          kontrol("unexpected_result", 1, 0);
        end else begin
          anlik = sb.pop_front();
          kontrol("hata", hata, anlik.hata);
          kontrol("seviye_farki", seviye_farki, anlik.fark);
          kontrol("derin_dugum", derin_dugum, anlik.derin);
          kontrol("ortak_ata", ortak_ata, anlik.ata);
          kontrol("latency", cyc - anlik.acc, anlik.lat);
        end
        gorundu = 1'b1;
      end else begin
        kontrol("hold_hata", hata, anlik.hata);
        kontrol("hold_seviye_farki", seviye_farki, anlik.fark);
        kontrol("hold_derin_dugum", derin_dugum, anlik.derin);
        kontrol("hold_ortak_ata", ortak_ata, anlik.ata);
      end
      if (cikis_hazir) begin
        gorundu = 1'b0;
        son_hs  = cyc;
      end
    end
  end

  task automatic istek(input int d1, input int y1, input int d2, input int y2, input bit cop);
    bek_t e;
    int   n = 0;
    @(negedge clk);
    while (!giris_hazir && n < 300) begin
      if (cop) begin
        giris_gecerli = $urandom_range(0, 1);
        dugum_1 = DW'($urandom_range(0, MAXN));
        dugum_2 = DW'($urandom_range(0, MAXN));
        yon_1   = 2'($urandom_range(0, 3));
        yon_2   = 2'($urandom_range(0, 3));
      end else begin
        giris_gecerli = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    if (!giris_hazir) begin
      kontrol("giris_hazir_timeout", 0, 1);
      giris_gecerli = 1'b0;
    end else begin
      giris_gecerli = 1'b1;
      dugum_1 = DW'(d1);
      dugum_2 = DW'(d2);
      yon_1   = 2'(y1);
      yon_2   = 2'(y2);
      e = model(d1, y1, d2, y2);
      e.acc = cyc + 1;
      if (b2b && son_hs >= 0) kontrol("b2b_accept_cycle", e.acc, son_hs + 2);
      sb.push_back(e);
      nvec++;
      @(negedge clk);
      giris_gecerli = 1'b0;
    end
  endtask

  task automatic bosalt();
    int n = 0;
    while ((sb.size() != 0 || cikis_gecerli) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || cikis_gecerli) kontrol("drain_timeout", 0, 1);
  endtask

  task automatic rastgele(input bit cop);
    int d1, d2;
    d1 = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, MAXN);
    d2 = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, MAXN);
    istek(d1, $urandom_range(0, 3), d2, $urandom_range(0, 3), cop);
  endtask

  initial begin
    rst_n = 1'b0;
    giris_gecerli = 1'b0;
    dugum_1 = '0; dugum_2 = '0; yon_1 = 2'b00; yon_2 = 2'b00;
    repeat (2) @(negedge clk);
    kontrol("rst_giris_hazir", giris_hazir, 1);
    kontrol("rst_cikis_gecerli", cikis_gecerli, 0);
    kontrol("rst_seviye_farki", seviye_farki, 0);
    kontrol("rst_derin_dugum", derin_dugum, 0);
    kontrol("rst_ortak_ata", ortak_ata, 0);
    kontrol("rst_hata", hata, 0);
    rst_n = 1'b1;

    // Directed cases: worked example, same node, and the three error kinds.
    kip = 1;
    istek(1, 1, 3, 2, 0);
    istek(5, 3, 5, 3, 0);
    istek(8, 1, 3, 3, 0);
    istek(1, 0, 2, 3, 0);
    istek(4, 3, 0, 3, 0);
    istek(2, 0, 3, 0, 0);
    istek(15, 3, 8, 3, 0);
    bosalt();

    // Consumer stalls three cycles; ignored input pulses while busy.
    kip = 2;
    istek(6, 2, 9, 0, 0);
    istek(7, 1, 2, 0, 1);
    istek(3, 0, 12, 1, 1);
    bosalt();

    kip = 0;
    repeat (60) rastgele($urandom_range(0, 1));
    bosalt();

    kip = 1;
    b2b = 1'b1;
    son_hs = -1;
    repeat (20) rastgele(0);
    bosalt();
    b2b = 1'b0;

    // Reset while the level count is in progress.
    istek(1, 1, 3, 2, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    kontrol("midrst_giris_hazir", giris_hazir, 1);
    kontrol("midrst_cikis_gecerli", cikis_gecerli, 0);
    kontrol("midrst_seviye_farki", seviye_farki, 0);
    kontrol("midrst_derin_dugum", derin_dugum, 0);
    kontrol("midrst_ortak_ata", ortak_ata, 0);
    kontrol("midrst_hata", hata, 0);
    sb.delete();
    gorundu = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    kontrol("post_reset_giris_hazir", giris_hazir, 1);
    istek(2, 1, 3, 0, 0);
    bosalt();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
